if_id_pipe: RTL
===============

# if_id_pipe

Parametrised IF/ID pipeline stage that replaces the single-entry fetch/decode latch. It accepts an instruction and its successor word from the fetch/cache side whenever the fetch reports a hit, and buffers up to DEPTH such pairs in a small FIFO. It presents them to decode with a valid/ready handshake, so decode stalls no longer drop fetched words. A synchronous flush supports branch redirect.

## Interface
- INST_W, 16, width of each instruction word
- DEPTH, 2, number of buffered instruction pairs; power of two, ≥ 2
- clk  in  1  stage clock; all state updates on the falling edge
- rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk
- hit  in  1  fetch valid: the instruction pair is valid this cycle
- instruction  in  INST_W  fetched instruction
- nextinstruction  in  INST_W  fetched successor word
- in_ready  out  1  stage can accept a pair (not full)
- flush  in  1  discard all buffered pairs (branch redirect)
- instOut  out  INST_W  head instruction to decode
- nextinstOut  out  INST_W  head successor word
- hitOut  out  1  head valid (FIFO non-empty)
- out_ready  in  1  decode consumes the head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer with write pointer, read pointer and occupancy count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- push = hit && in_ready. pop = hitOut && out_ready.
- in_ready = (count != DEPTH). This is combinational from state only and does not depend on out_ready; there is no pass-through when full.
- hitOut = (count != 0).
- When hitOut = 1, instOut and nextinstOut show the head entry. When hitOut = 0, both outputs are 0 (NOP).
- Priority at each falling edge: rst, then flush, then push/pop.
- rst: pointers and count go to 0, storage is cleared to 0, and the optional counter is cleared.
- flush: pointers and count go to 0. Any push or pop in the same cycle is ignored. Storage is not cleared.
- push and pop together: count is unchanged and both pointers advance. This is legal at any occupancy 1..DEPTH-1. At full, no push occurs. At empty, no pop occurs.
- A hit presented while in_ready = 0 is not captured. Fetch must hold or re-present it.

## Timing
- Reset values: hitOut 0, instOut 0, nextinstOut 0, count 0, in_ready 1.
- Latency: a pair pushed at falling edge N is visible on instOut/hitOut immediately after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one pair per cycle sustained when out_ready is held high.
- Outputs change only after falling edges, except in_ready/hitOut, which are decoded from state (no input-to-output combinational path).
- Reset or flush asserted mid-stream takes effect at that edge. A pair presented at that same edge is lost.

## Configuration
- IFID_STALL_CNT_EN defined: adds output port stall_cnt [31:0].
  - Increments at each falling edge where hitOut && !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst; flush does not clear it.
- IFID_STALL_CNT_EN undefined: no port and no counter logic.

## Structure
- Shared package: default INST_W, the IF/ID entry struct (inst, nextinst) and the NOP encoding (16'h0000).
- One sub-module, if_id_fifo_mem: DEPTH×(2·INST_W) storage with a falling-edge write port and a combinational read port. Pointer, count and handshake logic stay in if_id_pipe.

## Test plan
- Reset then idle: after rst, hitOut = 0, instOut = 0, in_ready = 1, count = 0. Holding hit = 0 for 5 cycles changes nothing.
- Streaming: DEPTH = 2, out_ready = 1, push pairs (16'h1111, 16'h2222) and (16'h3333, 16'h4444) on consecutive cycles. They appear in order one edge later, count never exceeds 1, and in_ready stays 1.
- Fill and stall: out_ready = 0, push 3 pairs. After two pushes count = 2 and in_ready = 0. The third pair is not stored. Release out_ready and exactly the first two pairs drain in order, with pointers wrapping.
- Simultaneous push/pop: count = 1, push 16'hAAAA while popping. count stays 1 and the head becomes 16'hAAAA.
- Flush priority: count = 2, assert flush together with hit and pair 16'h5555. Next cycle count = 0, hitOut = 0, instOut = 0, and 16'h5555 is absent.
- With IFID_STALL_CNT_EN: hold hitOut = 1 and out_ready = 0 for 7 edges. stall_cnt = 7, and it is unchanged by a subsequent flush.

Source files
------------

// File: rtl/if_id_pipe_pkg.sv
// rtl/if_id_pipe_pkg.sv - shared types and constants for the IF/ID pipeline stage
// Contents: default instruction width, IF/ID entry struct, NOP encoding.
package if_id_pipe_pkg;

  localparam int INST_W_DEF = 16;

  localparam logic [INST_W_DEF-1:0] NOP = 16'h0000;

  // One buffered fetch result: the instruction and the word that follows it.
  typedef struct packed {
    logic [INST_W_DEF-1:0] inst;
    logic [INST_W_DEF-1:0] nextinst;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// rtl/if_id_fifo_mem.sv - DEPTH x (2*INST_W) storage for the IF/ID FIFO
// Ports:
//   clk    in   stage clock, writes on the falling edge
//   rst    in   synchronous active-high clear of every entry
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   {inst, nextinst} entry to write
//   raddr  in   read address
//   rdata  out  entry at raddr (combinational)
module if_id_fifo_mem #(
  parameter int INST_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [2*INST_W-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [2*INST_W-1:0]      rdata
);

  logic [2*INST_W-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID pipeline stage buffering up to DEPTH instruction pairs
// Ports:
//   clk, rst                    falling-edge clock, synchronous active-high reset
//   hit, instruction,
//   nextinstruction, in_ready   fetch side: pair offered when hit, taken when in_ready
//   flush                       drop every buffered pair (branch redirect)
//   instOut, nextinstOut,
//   hitOut, out_ready           decode side: head pair, valid, consume
//   count                       current occupancy
//   stall_cnt                   only with IFID_STALL_CNT_EN: saturating count of
//                               edges where the head was valid but not consumed
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hit,
  input  logic [INST_W-1:0]        instruction,
  input  logic [INST_W-1:0]        nextinstruction,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [INST_W-1:0]        instOut,
  output logic [INST_W-1:0]        nextinstOut,
  output logic                     hitOut,
  input  logic                     out_ready,
`ifdef IFID_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                push;
  logic                pop;
  logic [2*INST_W-1:0] head;

  // Handshake is decoded from occupancy alone, so there is no path from
  // out_ready to in_ready and a full buffer never accepts a pass-through pair.
  assign in_ready = (count != CW'(DEPTH));
  assign hitOut   = (count != '0);
  assign push     = hit && in_ready;
  assign pop      = hitOut && out_ready;

  // Pointers are AW bits and DEPTH is a power of two, so plain increment wraps.
  always_ff @(negedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A flush wins over a push at the same edge, so the write is suppressed too.
  if_id_fifo_mem #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata ({instruction, nextinstruction}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale storage is masked so decode sees NOP whenever the buffer is empty.
  assign instOut     = hitOut ? head[2*INST_W-1:INST_W] : INST_W'(NOP);
  assign nextinstOut = hitOut ? head[INST_W-1:0]        : INST_W'(NOP);

`ifdef IFID_STALL_CNT_EN
  // Survives flush so redirect-heavy code still shows its decode backpressure.
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hitOut && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
